// File: rtl/mem_stage_pkg.sv
// Shared widths and field positions for the memory-access stage.
package mem_stage_pkg;
    localparam int DATA_W           = 32;
    localparam int DEST_W           = 5;
    localparam int PASS_EX_W        = 7;
    localparam int PASS_MEM_W       = 6;
    localparam int RES_FROM_MEM_BIT = 6;
    localparam int GR_WE_BIT        = 5;
endpackage

// File: rtl/mem_ld_hold.sv
// Holds SRAM load data across write-back stalls: the SRAM output is only
// valid in an instruction's first cycle here, so it is buffered if the instruction stays.
module mem_ld_hold
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_accept,
    input  logic              i_mem_valid,
    input  logic              i_wb_allow_in,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_ld_data
);
    logic              r_first_cycle_p1;
    logic [DATA_W-1:0] r_ld_buf_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_first_cycle_p1 <= 1'b0;
            r_ld_buf_p1      <= '0;
        end else begin
            r_first_cycle_p1 <= i_accept;
            if (r_first_cycle_p1 && i_mem_valid && !i_wb_allow_in)
                r_ld_buf_p1 <= i_rdata;
        end
    end

    assign o_ld_data = r_first_cycle_p1 ? i_rdata : r_ld_buf_p1;
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches execute results, merges SRAM load
// data and forwards the in-flight destination/result to decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EXU_to_MEM_valid,
    output logic                  MEM_allow_in,
    input  logic [DATA_W-1:0]     EXU_pc_to_MEM,
    input  logic [DATA_W-1:0]     EXU_inst_to_MEM,
    input  logic [DATA_W-1:0]     EXU_result_to_MEM,
    input  logic [PASS_EX_W-1:0]  EXU_signals_pass_to_MEM,
    input  logic [DATA_W-1:0]     data_sram_rdata,
    input  logic                  WB_allow_in,
    output logic                  MEM_ready_go,
    output logic                  MEM_to_WB_valid,
    output logic [DATA_W-1:0]     MEM_pc_to_WB,
    output logic [DATA_W-1:0]     MEM_inst_to_WB,
    output logic [DATA_W-1:0]     MEM_final_result,
    output logic [PASS_MEM_W-1:0] MEM_signals_pass_to_WB,
    output logic                  MEM_to_IDU_gr_we,
    output logic [DEST_W-1:0]     MEM_to_IDU_dest,
    output logic                  MEM_to_IDU_valid,
    output logic [DATA_W-1:0]     MEM_to_IDU_forward
);
    logic                 r_valid_p1;
    logic [DATA_W-1:0]    r_pc_p1;
    logic [DATA_W-1:0]    r_inst_p1;
    logic [DATA_W-1:0]    r_result_p1;
    logic [PASS_EX_W-1:0] r_pass_p1;
    logic                 w_accept;
    logic [DATA_W-1:0]    w_ld_data;

    assign MEM_ready_go = 1'b1;
    assign MEM_allow_in = !r_valid_p1 || (MEM_ready_go && WB_allow_in);
    assign w_accept     = EXU_to_MEM_valid && MEM_allow_in;

    // Execute -> memory boundary; data registers only move on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_p1  <= 1'b0;
            r_pc_p1     <= '0;
            r_inst_p1   <= '0;
            r_result_p1 <= '0;
            r_pass_p1   <= '0;
        end else begin
            if (MEM_allow_in)
                r_valid_p1 <= EXU_to_MEM_valid;
            if (w_accept) begin
                r_pc_p1     <= EXU_pc_to_MEM;
                r_inst_p1   <= EXU_inst_to_MEM;
                r_result_p1 <= EXU_result_to_MEM;
                r_pass_p1   <= EXU_signals_pass_to_MEM;
            end
        end
    end

    mem_ld_hold u_ld_hold (
        .clk           (clk),
        .reset         (reset),
        .i_accept      (w_accept),
        .i_mem_valid   (r_valid_p1),
        .i_wb_allow_in (WB_allow_in),
        .i_rdata       (data_sram_rdata),
        .o_ld_data     (w_ld_data)
    );

    assign MEM_to_WB_valid        = r_valid_p1 && MEM_ready_go;
    assign MEM_pc_to_WB           = r_pc_p1;
    assign MEM_inst_to_WB         = r_inst_p1;
    assign MEM_final_result       = r_pass_p1[RES_FROM_MEM_BIT] ? w_ld_data : r_result_p1;
    assign MEM_signals_pass_to_WB = r_pass_p1[PASS_MEM_W-1:0];
    assign MEM_to_IDU_gr_we       = r_pass_p1[GR_WE_BIT];
    assign MEM_to_IDU_dest        = r_pass_p1[DEST_W-1:0];
    assign MEM_to_IDU_valid       = r_valid_p1;
    assign MEM_to_IDU_forward     = MEM_final_result;
endmodule
